// File: rtl/mc_pulse_sync_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_pulse_sync_rx : multi-channel toggle-to-pulse synchronizer receiver,    |
// |                    with per-channel event backlog and pulse spacing.       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mc_pulse_sync_rx #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int MIN_GAP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] in_tgl,
  output logic [NUM_CH-1:0] ack_tgl,
  output logic [NUM_CH-1:0] out_pulse,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] ovf,
  input  logic [NUM_CH-1:0] ovf_clr
);

  localparam logic [CNT_W-1:0] PEND_MAX  = '1;
  localparam logic [CNT_W-1:0] PEND_ZERO = '0;
  localparam logic [CNT_W-1:0] PEND_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       GAP_LOAD  = 4'(MIN_GAP);
  localparam logic [3:0]       GAP_ONE   = 4'd1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic [3:0]             gap_q, gap_d;
    logic                   pulse_q, pulse_d;
    logic                   ovf_q, ovf_d;
    logic                   sync_out;
    logic                   event_w;
    logic                   fire_w;
    logic                   drop_w;

    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], in_tgl[c]};
      sync_out = sync_q[SYNC_STAGES-1];
      prev_d   = sync_out;
      event_w  = sync_out ^ prev_q;
      fire_w   = (gap_q == 4'd0) && ((pend_q != PEND_ZERO) || event_w);
      drop_w   = 1'b0;
      pend_d   = pend_q;

      // An event that arrives while firing replaces the consumed one, so
      // the backlog only moves when exactly one of the two happens.
      if (fire_w && !event_w) begin
        pend_d = pend_q - PEND_ONE;
      end else if (!fire_w && event_w) begin
        if (pend_q == PEND_MAX) begin
          drop_w = 1'b1;
        end else begin
          pend_d = pend_q + PEND_ONE;
        end
      end

      if (fire_w) begin
        gap_d = GAP_LOAD;
      end else if (gap_q != 4'd0) begin
        gap_d = gap_q - GAP_ONE;
      end else begin
        gap_d = 4'd0;
      end

      pulse_d = fire_w;
      // A drop in the same cycle as a clear keeps the flag raised.
      ovf_d   = drop_w | (ovf_q & ~ovf_clr[c]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        prev_q  <= 1'b0;
        pend_q  <= '0;
        gap_q   <= 4'd0;
        pulse_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        prev_q  <= prev_d;
        pend_q  <= pend_d;
        gap_q   <= gap_d;
        pulse_q <= pulse_d;
        ovf_q   <= ovf_d;
      end
    end

    assign ack_tgl[c]   = prev_q;
    assign out_pulse[c] = pulse_q;
    assign busy[c]      = (pend_q != PEND_ZERO) || (gap_q != 4'd0);
    assign ovf[c]       = ovf_q;
  end

endmodule
`default_nettype wire

// File: doc/mc_pulse_sync_rx.md
MC_PULSE_SYNC_RX -- requirements
Module: mc_pulse_sync_rx

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_CH, 4, channel count (1..16)
- SYNC_STAGES, 2, synchronizer flops per channel (2..4)
- CNT_W, 4, pending-event counter width (2..8)
- MIN_GAP, 1, idle cycles between output pulses on one channel (1..15)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, destination clock
- rst_n, input, 1, asynchronous active-low reset
- in_tgl, input, NUM_CH, asynchronous per-channel toggle; each transition is one event
- ack_tgl, output, NUM_CH, synchronized copy of in_tgl, returned to the source domain for feedback
- out_pulse, output, NUM_CH, one-cycle event pulse per delivered event
- busy, output, NUM_CH, channel holds undelivered events or is in its gap
- ovf, output, NUM_CH, sticky per-channel overflow flag
- ovf_clr, input, NUM_CH, synchronous clear of ovf
REQ-003 Clock SHALL be one clock, clk. Reset SHALL be asynchronous and active-low, rst_n.

Function (per channel c, all channels independent and identical)
REQ-004 in_tgl[c] SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (s_c) is used downstream.
REQ-005 A register prev_c SHALL capture s_c each cycle; event_c = s_c XOR prev_c.
REQ-006 ack_tgl[c] SHALL equal prev_c (registered output, no combinational path from in_tgl).
REQ-007 State per channel SHALL be pend_c (CNT_W bits), gap_c (4 bits), out_pulse[c] (registered).
REQ-008 At each clk edge: fire_c = (gap_c == 0) AND (pend_c != 0 OR event_c).
REQ-009 out_pulse[c] SHALL be loaded with fire_c, so each fire produces exactly one high cycle.
REQ-010 gap_c SHALL load MIN_GAP on fire_c, else decrement when nonzero, else hold 0.
REQ-011 pend_c update: +event_c -fire_c. A simultaneous event and fire SHALL leave pend_c unchanged. An event with pend_c == 0 and fire SHALL bypass the counter (pend_c stays 0).
REQ-012 Saturation: an event_c with pend_c == 2^CNT_W-1 and no fire SHALL be dropped, and ovf[c] SHALL be set.
REQ-013 ovf[c] SHALL be cleared by ovf_clr[c]=1 at a clk edge. If set and clear occur in the same cycle, set SHALL win.
REQ-014 busy[c] SHALL be (pend_c != 0) OR (gap_c != 0), combinational from registers.
REQ-015 Latency: an in_tgl[c] toggle captured at edge 1, with an idle channel, SHALL give out_pulse[c] high in the cycle after edge SYNC_STAGES+1.
REQ-016 Minimum spacing: consecutive out_pulse[c] highs SHALL be separated by at least MIN_GAP low cycles. Sustained throughput is one pulse per MIN_GAP+1 cycles.
REQ-017 No events SHALL be lost unless ovf[c] is set. Delivered count plus dropped count SHALL equal the number of toggles.
REQ-018 Source-side rule (documented contract): the source SHALL NOT toggle in_tgl[c] again until it observes ack_tgl[c] equal to its own value. Violations may merge toggles; the block does not detect this.

Reset
REQ-019 On rst_n low, all sync flops, prev, pend, gap, out_pulse and ovf SHALL go to 0 immediately. Outputs: out_pulse=0, ack_tgl=0, busy=0, ovf=0.
REQ-020 Reset mid-operation SHALL discard all pending events without emitting pulses.
REQ-021 If in_tgl[c]=1 at reset release, exactly one event SHALL be generated on channel c.

Verification
REQ-022 Scenario: SYNC_STAGES=2, single toggle on ch0, captured at edge 1 -> out_pulse[0] high only in the cycle after edge 3; ack_tgl[0]=1 from edge 3.
REQ-023 Scenario: MIN_GAP=3, 5 toggles on ch1 spaced 2 cycles apart -> 5 pulses, each separated by at least 3 low cycles; busy[1] falls 3 cycles after the last pulse; ovf=0.
REQ-024 Scenario: CNT_W=2, MIN_GAP=15, 6 rapid toggles on ch2 -> 1 bypass fire, pend saturates at 3, 2 events dropped, ovf[2]=1, exactly 4 pulses total.
REQ-025 Scenario: ovf[2]=1 and ovf_clr[2]=1 in the same cycle as a new drop -> ovf[2] stays 1; ovf_clr[2] alone next cycle -> ovf[2]=0.
REQ-026 Scenario: pend_c=3 on ch0 and rst_n asserted mid-gap -> all outputs 0 at once; no pulse after release with in_tgl=0.
REQ-027 Scenario: simultaneous toggles on all NUM_CH=4 channels -> 4 pulses in the same cycle, fully independent; random async in_tgl stimulus honouring REQ-018 -> pulse count equals toggle count per channel.
